// File: rtl/bytewrite_ram_port_master.sv
// -----------------------------------------------------------------------------
// bytewrite_ram_port_master
//
// Initiator for one port of a byte-write true-dual-port RAM. The RAM registers
// both the address and the data output, so it has RD_LAT cycles of read
// latency. This block turns a valid/ready request stream into RAM port drive
// signals and returns the read data, in request order, on a valid/ready
// response stream.
//
// Request acceptance is credit based. A read takes one credit from the moment
// it is accepted until its response is popped from the response FIFO. The FIFO
// therefore always has room for every read that is still travelling through
// the RAM, and no RAM output is ever dropped.
//
// Optional feature (compile-time macro BRPM_STATS_EN):
//   Adds the free-running counters stat_rd_cnt_o, stat_wr_cnt_o and
//   stat_stall_o. When the macro is undefined these ports do not exist.
//
// Ports:
//   clk_i          clock, shared with the RAM port
//   rst_i          synchronous active-high reset
//   req_valid_i    request present
//   req_ready_o    request accepted when req_valid_i & req_ready_o
//   req_we_i       byte write enables; all-zero means read
//   req_addr_i     word address
//   req_wdata_i    write data; lane i is bits [8i+7:8i]
//   rsp_valid_o    read data present
//   rsp_ready_i    consumer takes rsp_rdata_o when rsp_valid_o & rsp_ready_i
//   rsp_rdata_o    read data, in request order
//   ram_we_o       RAM byte write enables
//   ram_addr_o     RAM address
//   ram_din_o      RAM write data
//   ram_dout_i     RAM read data
//   stat_rd_cnt_o  (BRPM_STATS_EN) accepted reads, wraps at 2**32
//   stat_wr_cnt_o  (BRPM_STATS_EN) accepted writes, wraps at 2**32
//   stat_stall_o   (BRPM_STATS_EN) cycles with req_valid_i & ~req_ready_o
// -----------------------------------------------------------------------------
module bytewrite_ram_port_master #(
  parameter int AW        = 10,
  parameter int NB        = 4,
  parameter int DW        = NB * 8,
  parameter int RD_LAT    = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [NB-1:0] req_we_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_rdata_o,
  output logic [NB-1:0] ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_din_o,
  input  logic [DW-1:0] ram_dout_i
`ifdef BRPM_STATS_EN
  ,
  output logic [31:0]   stat_rd_cnt_o,
  output logic [31:0]   stat_wr_cnt_o,
  output logic [31:0]   stat_stall_o
`endif
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int UW = $clog2(RSP_DEPTH + RD_LAT + 1) + 1;

  logic              fire;
  logic              rd_fire;
  logic              push;
  logic              pop;
  logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]     fifo_mem_q [RSP_DEPTH];
  logic [UW-1:0]     pipe_cnt;
  logic [UW-1:0]     used;

  // Pointers wrap at RSP_DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits in use: reads still inside the RAM plus responses waiting in the
  // FIFO. Both terms are registered, so a pop frees its credit one cycle late.
  always_comb begin
    pipe_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      pipe_cnt = pipe_cnt + UW'(rd_pipe_q[i]);
    end
    used = pipe_cnt + UW'(fifo_cnt_q);
  end

  // Ready does not look at req_we_i: writes also wait for a free credit,
  // which keeps the request ordering simple for the upstream side.
  assign req_ready_o = ~rst_i & (used < UW'(RSP_DEPTH));
  assign fire        = req_valid_i & req_ready_o;
  assign rd_fire     = fire & ~|req_we_i;

  // fire already includes ~rst_i, so ram_we_o is zero throughout reset.
  assign ram_we_o   = fire ? req_we_i : '0;
  assign ram_addr_o = req_addr_i;
  assign ram_din_o  = req_wdata_i;

  // The top bit of the read pipe marks the cycle when ram_dout_i carries the
  // data for the read accepted RD_LAT cycles earlier.
  assign push = rd_pipe_q[RD_LAT-1];
  assign pop  = rsp_valid_o & rsp_ready_i;

  assign rsp_valid_o = (fifo_cnt_q != '0);
  assign rsp_rdata_o = fifo_mem_q[rd_ptr_q];

  always_comb begin
    rd_pipe_d    = '0;
    rd_pipe_d[0] = rd_fire;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_pipe_d[i] = rd_pipe_q[i-1];
    end
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Clearing the read pipe on reset drops every in-flight read, so the RAM
  // outputs they would have produced are never pushed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_pipe_q  <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      rd_pipe_q  <= rd_pipe_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage is cleared on reset so the head entry, and thus rsp_rdata_o,
  // reads zero after reset. When the FIFO is full a simultaneous push and
  // pop target the same slot: the head is read out this cycle and the new
  // word lands at the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else if (push) begin
      fifo_mem_q[wr_ptr_q] <= ram_dout_i;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push && fifo_cnt_q == CW'(RSP_DEPTH)))
        else $error("bytewrite_ram_port_master: response FIFO pushed while full");
    end
  end
`endif

`ifdef BRPM_STATS_EN
  logic [31:0] stat_rd_q, stat_rd_d;
  logic [31:0] stat_wr_q, stat_wr_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_rd_d    = stat_rd_q + {31'd0, rd_fire};
    stat_wr_d    = stat_wr_q + {31'd0, fire & |req_we_i};
    stat_stall_d = stat_stall_q + {31'd0, req_valid_i & ~req_ready_o};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_rd_q    <= '0;
      stat_wr_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_rd_q    <= stat_rd_d;
      stat_wr_q    <= stat_wr_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_rd_cnt_o = stat_rd_q;
  assign stat_wr_cnt_o = stat_wr_q;
  assign stat_stall_o  = stat_stall_q;
`endif

endmodule

// File: tb/tb_bytewrite_ram_port_master.sv
// -----------------------------------------------------------------------------
// tb_bytewrite_ram_port_master
//
// Directed bench for bytewrite_ram_port_master with a behavioural byte-write
// RAM port (registered address, registered data out, 2-cycle read latency).
// Inputs change 1 time unit after the rising edge; outputs are sampled 3 time
// units after the rising edge; responses are logged on the falling edge.
// -----------------------------------------------------------------------------
module tb_bytewrite_ram_port_master;
  localparam int AW = 10;
  localparam int NB = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [NB-1:0] req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [NB-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
`ifdef BRPM_STATS_EN
  logic [31:0]   stat_rd_cnt;
  logic [31:0]   stat_wr_cnt;
  logic [31:0]   stat_stall;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0] rsp_q[$];
  int            rsp_cyc_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  bytewrite_ram_port_master #(
    .AW(AW), .NB(NB), .DW(DW), .RD_LAT(2), .RSP_DEPTH(4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_din_o   (ram_din),
    .ram_dout_i  (ram_dout)
`ifdef BRPM_STATS_EN
    ,
    .stat_rd_cnt_o (stat_rd_cnt),
    .stat_wr_cnt_o (stat_wr_cnt),
    .stat_stall_o  (stat_stall)
`endif
  );

  // Preload pattern for words never written through the port.
  function automatic logic [DW-1:0] pat(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // Behavioural RAM port: address register, byte-masked write at the edge,
  // output register fed from the address register (write-first for a read
  // issued the cycle after a write).
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] ram_addr_reg;
  logic          mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int a = 0; a < (1 << AW); a++) mem[a] <= pat(a);
      mem_loaded   <= 1'b1;
      ram_addr_reg <= '0;
      ram_dout     <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
      end
      ram_addr_reg <= ram_addr;
      ram_dout     <= mem[ram_addr_reg];
    end
  end

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      rsp_q.push_back(rsp_rdata);
      rsp_cyc_q.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
    $display("check %-14s got %0h want %0h", tag, obs, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int guard;
    int notready;
    int stale;

    rst       = 1'b1;
    req_valid = 1'b1;
    req_we    = 4'hF;
    req_addr  = '0;
    req_wdata = 32'h1234_5678;
    rsp_ready = 1'b0;

    // Reset state, with a write request held during reset.
    repeat (3) tick();
    #2;
    check("rst_ready", req_ready, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_rsp_vld", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    tick();
    rst = 1'b0; req_valid = 1'b0; req_we = '0;
    #2;
    check("post_rst_rdy", req_ready, 1);
    check("post_rst_vld", rsp_valid, 0);

    // 1. Full write then read of 0x005; response at fire cycle + 3.
    tick();
    req_valid = 1'b1; req_we = 4'hF; req_addr = 10'h005; req_wdata = 32'h1122_3344;
    rsp_ready = 1'b1;
    #2;
    check("wr_ram_we", ram_we, 4'hF);
    check("wr_ram_addr", ram_addr, 10'h005);
    check("wr_ram_din", ram_din, 32'h1122_3344);
    tick();
    req_we = '0;
    #2;
    check("rd_ram_we", ram_we, 0);
    check("rd_ready", req_ready, 1);
    tick(); req_valid = 1'b0; #2;
    check("t1_vld_n1", rsp_valid, 0);
    tick(); #2;
    check("t1_vld_n2", rsp_valid, 0);
    tick(); #2;
    check("t1_vld_n3", rsp_valid, 1);
    check("t1_rdata", rsp_rdata, 32'h1122_3344);
    tick(); #2;
    check("t1_vld_n4", rsp_valid, 0);

    // 2. Byte-lane merge: only lane 1 written.
    tick();
    req_valid = 1'b1; req_we = 4'b0010; req_addr = 10'h005; req_wdata = 32'hAAAA_BBAA;
    #2;
    tick(); req_we = '0; #2;
    tick(); req_valid = 1'b0; #2;
    tick(); #2;
    check("t2_vld_n2", rsp_valid, 0);
    tick(); #2;
    check("t2_vld_n3", rsp_valid, 1);
    check("t2_rdata", rsp_rdata, 32'h1122_BB44);
    tick(); #2;

    // 3. Backpressure: 6 reads offered with rsp_ready low.
    rsp_q.delete(); rsp_cyc_q.delete();
    rsp_ready = 1'b0;
    acc = 0;
    repeat (8) begin
      tick();
      req_valid = 1'b1; req_we = '0; req_addr = AW'(10'h010 + acc);
      #2;
      if (req_ready) acc++;
    end
    check("t3_accepted", acc, 4);
    check("t3_ready_low", req_ready, 0);
    check("t3_rsp_vld", rsp_valid, 1);
    check("t3_no_rsp", rsp_q.size(), 0);
    guard = 0;
    while (!(acc == 6 && rsp_q.size() == 6) && guard < 40) begin
      tick();
      rsp_ready = 1'b1;
      if (acc < 6) begin
        req_valid = 1'b1; req_addr = AW'(10'h010 + acc);
      end else begin
        req_valid = 1'b0;
      end
      #2;
      if (req_valid && req_ready) acc++;
      guard++;
    end
    req_valid = 1'b0;
    check("t3_timeout", guard < 40, 1);
    check("t3_total_acc", acc, 6);
    check("t3_rsp_cnt", rsp_q.size(), 6);
    for (int i = 0; i < 6 && i < rsp_q.size(); i++) begin
      check($sformatf("t3_data%0d", i), rsp_q[i], pat(10'h010 + i));
    end

    // 4. Throughput: 100 back-to-back reads with rsp_ready high.
    tick(); #2;
    rsp_q.delete(); rsp_cyc_q.delete();
    notready = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      req_valid = 1'b1; req_we = '0; req_addr = AW'(10'h100 + i);
      #2;
      if (!req_ready) notready++;
    end
    tick(); req_valid = 1'b0; #2;
    guard = 0;
    while (rsp_q.size() < 100 && guard < 20) begin
      tick(); #2;
      guard++;
    end
    check("t4_notready", notready, 0);
    check("t4_rsp_cnt", rsp_q.size(), 100);
    acc = 0;
    for (int i = 0; i < rsp_q.size(); i++) begin
      if (rsp_q[i] !== pat(10'h100 + i)) acc++;
    end
    check("t4_data_errs", acc, 0);
    if (rsp_q.size() == 100) check("t4_no_gaps", rsp_cyc_q[99] - rsp_cyc_q[0], 99);

    // 5. Reset with 2 reads in flight and 2 responses queued.
    rsp_q.delete(); rsp_cyc_q.delete();
    rsp_ready = 1'b0;
    tick();
    req_valid = 1'b1; req_we = 4'hF; req_addr = 10'h020; req_wdata = 32'hDEAD_BEEF;
    #2;
    check("t5_wr_ready", req_ready, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      req_we = '0; req_addr = AW'(10'h030 + k);
      #2;
      check($sformatf("t5_rd_ready%0d", k), req_ready, 1);
    end
    tick();
    req_valid = 1'b0; rst = 1'b1;
    #2;
    check("t5_pre_vld", rsp_valid, 1);
    check("t5_rst_ready", req_ready, 0);
    tick();
    rst = 1'b0;
    #2;
    check("t5_post_vld", rsp_valid, 0);
    check("t5_post_rdata", rsp_rdata, 0);
    check("t5_post_ready", req_ready, 1);
    rsp_ready = 1'b1;
    stale = 0;
    repeat (10) begin
      tick(); #2;
      if (rsp_valid) stale++;
    end
    check("t5_stale_vld", stale, 0);
    check("t5_stale_rsp", rsp_q.size(), 0);
    tick();
    req_valid = 1'b1; req_we = '0; req_addr = 10'h020;
    #2;
    tick(); req_valid = 1'b0; #2;
    tick(); #2;
    tick(); #2;
    check("t5_rd_vld", rsp_valid, 1);
    check("t5_rd_data", rsp_rdata, 32'hDEAD_BEEF);
    tick(); #2;

`ifdef BRPM_STATS_EN
    // 6. Statistics: 7 writes, 5 reads, 3 stall cycles.
    tick(); rst = 1'b1; req_valid = 1'b0; #2;
    tick(); rst = 1'b0; #2;
    check("t6_rd_zero", stat_rd_cnt, 0);
    check("t6_wr_zero", stat_wr_cnt, 0);
    check("t6_st_zero", stat_stall, 0);
    rsp_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      req_valid = 1'b1; req_we = 4'hF; req_addr = AW'(10'h040 + k); req_wdata = 32'(k);
      #2;
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      req_valid = 1'b1; req_we = '0; req_addr = 10'h040;
      rsp_ready = (c >= 6);
      #2;
      check($sformatf("t6_ready_c%0d", c), req_ready, (c < 4 || c == 7) ? 1 : 0);
    end
    tick(); req_valid = 1'b0; #2;
    check("t6_wr_cnt", stat_wr_cnt, 7);
    check("t6_rd_cnt", stat_rd_cnt, 5);
    check("t6_stall", stat_stall, 3);
    rsp_ready = 1'b1;
    repeat (10) tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
